// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: occupancy states and default widths shared by the FIFO, its reader and their benches.
package sync_fifo_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CNT_WIDTH  = 16;
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data, valid the cycle after an accepted pop.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    localparam int AW = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic                  i_rd_en,
    output logic [DATA_WIDTH-1:0] o_dout,
    output logic                  o_empty,
    output logic                  o_full,
    output logic [AW:0]           o_count
);
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wp, r_rp;
    logic [AW:0]           r_cnt;
    logic                  w_wr, w_rd;
    assign w_wr    = i_wr_en && !o_full;
    assign w_rd    = i_rd_en && !o_empty;
    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == (AW+1)'(FIFO_DEPTH));
    assign o_count = r_cnt;
    always_ff @(posedge clk)
        if (w_wr) r_mem[r_wp] <= i_din;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            o_dout <= '0;
        end else begin
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_rd) begin
                r_rp   <= r_rp + 1'b1;
                o_dout <= r_mem[r_rp];
            end
            r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
        end
    end
endmodule

// File: rtl/sync_fifo_reader.sv
// sync_fifo_reader: pops the FIFO into a registered valid/ready stream through a two-entry skid,
// issuing a pop only when a slot is guaranteed for the word it returns.
module sync_fifo_reader import sync_fifo_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  rd_count
);
    occ_e                  r_occ, w_occ_nxt;
    logic                  r_pend;
    logic [DATA_WIDTH-1:0] r_head, r_skid;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  w_pop, w_head_free;
    assign w_pop       = (r_occ != EMPTY) && m_ready;
    assign w_head_free = (r_occ == EMPTY) || (r_occ == ONE && w_pop);
    // words held plus the one in flight must still fit after this cycle's pop
    assign fifo_rd_en  = !rst && !fifo_empty && ({1'b0, r_occ} + {2'b0, r_pend} < 3'd2 + {2'b0, w_pop});
    assign m_valid     = (r_occ != EMPTY);
    assign m_data      = r_head;
    assign rd_count    = r_cnt;
    always_comb begin
        w_occ_nxt = r_occ;
        w_occ_nxt = (r_occ == EMPTY) ? (r_pend ? ONE : EMPTY) :
                    (r_occ == ONE)   ? ((r_pend && !w_pop) ? TWO : (!r_pend && w_pop) ? EMPTY : ONE) :
                                       ((w_pop && !r_pend) ? ONE : TWO);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ  <= EMPTY;
            r_pend <= 1'b0;
            r_head <= '0;
            r_skid <= '0;
            r_cnt  <= '0;
        end else begin
            r_occ  <= w_occ_nxt;
            r_pend <= fifo_rd_en;
            r_cnt  <= r_cnt + CNT_WIDTH'(fifo_rd_en);
            if (r_pend && w_head_free) r_head <= fifo_dout;
            else if (w_pop && r_occ == TWO) r_head <= r_skid;
            if (r_pend && !w_head_free) r_skid <= fifo_dout;
        end
    end
    assert property (@(posedge clk) disable iff (rst) !(r_occ == TWO && r_pend && !w_pop));
endmodule
